// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter:
//   - state_e         : FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - SB_TICK_DEFAULT : default number of oversampling ticks per bit
//   - calc_divisor()  : clock-to-tick divisor, round(clk_freq / (baud * sb_tick))
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam int SB_TICK_DEFAULT = 16;

    // Rounded integer division; adding half the denominator rounds to nearest.
    function automatic int calc_divisor(input int clk_freq, input int baud, input int sb_tick);
        int den;
        den = baud * sb_tick;
        return (clk_freq + (den / 32'sd2)) / den;
    endfunction

endpackage

// File: rtl/uart_tx_baud_rate_gen.sv
// -----------------------------------------------------------------------------
// baud_rate_gen
// Mod-N counter producing a one-clock s_tick pulse every N clocks.
// Parameters:
//   N       : divisor (>= 2)
// Ports:
//   clk     in   system clock (posedge)
//   reset   in   synchronous active-high reset
//   clr     in   synchronous counter clear (restarts the tick phase)
//   s_tick  out  registered one-cycle pulse every N clocks
// After reset or clr, the first s_tick is high in the N-th following cycle.
// -----------------------------------------------------------------------------
module baud_rate_gen #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic s_tick
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Next count and look-ahead tick so that s_tick can come straight from a flop.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        tick_d = (cnt_d == CNT_LAST);
    end

    // Counter and tick registers with synchronous reset/clear.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign s_tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: one DBIT-wide word per request, LSB first, one stop bit,
// SB_TICK oversampling ticks per bit.
// Optional feature macro: UART_TX_PARITY_EN -- when defined an even parity bit
// (XOR of the captured word) is sent between the last data bit and the stop bit.
// Parameters:
//   DBIT, SB_TICK, CLK_FREQ, BAUD  (divisor N = round(CLK_FREQ/(BAUD*SB_TICK)), N >= 2)
// Ports:
//   clk           in   system clock (posedge)
//   reset         in   synchronous active-high reset
//   tx_start      in   send request, sampled only while idle
//   din           in   word to send, captured on the accepting edge
//   tx            out  registered serial line, idles high
//   tx_busy       out  high from the cycle after acceptance until frame end
//   tx_done_tick  out  one-clock pulse in the final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = SB_TICK_DEFAULT,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 19200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int N  = calc_divisor(CLK_FREQ, BAUD, SB_TICK);
    localparam int TW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

    state_e          state_q;
    state_e          state_d;
    logic [TW-1:0]   tick_q;
    logic [TW-1:0]   tick_d;
    logic [BW-1:0]   bit_q;
    logic [BW-1:0]   bit_d;
    logic [DBIT-1:0] shreg_q;
    logic [DBIT-1:0] shreg_d;
    logic            tx_q;
    logic            tx_d;
    logic            busy_q;
    logic            clr_s;
    logic            done_s;
    logic            s_tick_s;
`ifdef UART_TX_PARITY_EN
    logic            parity_q;
    logic            parity_d;
`endif

    baud_rate_gen #(
        .N (N)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_s),
        .s_tick (s_tick_s)
    );

    // Next-state, datapath updates and the value tx takes in the next state.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        clr_s    = 1'b0;
        done_s   = 1'b0;
        tx_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d  = START;
                    tick_d   = '0;
                    bit_d    = '0;
                    shreg_d  = din;
                    clr_s    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^din;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (s_tick_s) begin
                    if (tick_q == TICK_LAST) begin
                        state_d = DATA;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            DATA: begin
                if (s_tick_s) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shreg_d = {1'b0, shreg_q[DBIT-1:1]};
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick_s) begin
                    if (tick_q == TICK_LAST) begin
                        state_d = STOP;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
`endif
            STOP: begin
                if (s_tick_s) begin
                    if (tick_q == TICK_LAST) begin
                        // s_tick marks the last cycle of this tick period,
                        // so this is the final cycle of the stop bit.
                        state_d = IDLE;
                        tick_d  = '0;
                        done_s  = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx is registered, so it is derived from the state being entered.
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            busy_q   <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    // Decoded purely from flops (state_q, tick_q and the registered s_tick).
    assign tx_done_tick = done_s;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx at CLK_FREQ=1.6 MHz, BAUD=10 kbaud
// (N=10, 160 clocks per bit). A frame-level model predicts tx, tx_busy and
// tx_done_tick every cycle from the elapsed time since the accepting edge;
// directed frames additionally pin line levels and timing to literal values.
// Build with +define+UART_TX_PARITY_EN to cover the parity variant.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BITCYC   = 160;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam int FRAME_LIT = 1760;
    localparam logic [10:0] A5_BITS  = 11'b101_0100_1010;
    localparam logic [10:0] R81_BITS = 11'b101_0000_0010;
    localparam logic [10:0] P07_BITS = 11'b110_0000_1110;
`else
    localparam int NBITS = 10;
    localparam int FRAME_LIT = 1600;
    localparam logic [10:0] A5_BITS  = 11'b011_0100_1010;
    localparam logic [10:0] R81_BITS = 11'b011_0000_0010;
`endif
    localparam int FLEN = NBITS * BITCYC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;

    int n_pass  = 0;
    int n_total = 0;

    uart_tx #(
        .DBIT     (DBIT),
        .SB_TICK  (SB_TICK),
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start),
        .din          (din),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Level of frame slot idx: start, data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Frame-level model: idle, or busy with a cycle count since acceptance.
    bit         m_busy = 1'b0;
    int         m_el   = 0;
    logic [7:0] m_byte = 8'h00;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_el   <= 0;
        end else if (!m_busy) begin
            if (tx_start) begin
                m_busy <= 1'b1;
                m_el   <= 1;
                m_byte <= din;
            end
        end else if (m_el == FLEN) begin
            m_busy <= 1'b0;
        end else begin
            m_el <= m_el + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [2:0] e;
            if (!m_busy) e = 3'b100;
            else e = {frame_bit(m_byte, (m_el - 1) / BITCYC), 1'b1, (m_el == FLEN)};
            check("model_tx_busy_done", {29'd0, tx, tx_busy, tx_done_tick}, {29'd0, e});
        end
    end

    // Send one word and check mid-bit levels, done count and done timing.
    task automatic literal_frame(input string nm, input logic [7:0] b,
                                 input logic [10:0] exp_bits, input int exp_len, input bit inject);
        int done_cnt;
        int done_at;
        done_cnt = 0;
        done_at  = -1;
        @(negedge clk);
        din      = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int k = 1; k <= exp_len + 1; k++) begin
            if (k > 1) @(negedge clk);
            if ((k % BITCYC) == (BITCYC / 2) && k <= exp_len)
                check({nm, "_bit"}, {31'd0, tx}, {31'd0, exp_bits[k / BITCYC]});
            if (tx_done_tick) begin
                done_cnt++;
                done_at = k;
            end
            if (inject && k == 500) begin
                din      = 8'hFF;
                tx_start = 1'b1;
            end else if (inject && k == 501) begin
                din      = b;
                tx_start = 1'b0;
            end
        end
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_done_at"}, done_at, exp_len);
        check({nm, "_busy_after"}, {31'd0, tx_busy}, 32'd0);
    endtask

    // Wait (bounded) for a done pulse; returns 1 when seen.
    task automatic wait_done(output bit seen);
        int t;
        t    = 0;
        seen = 1'b0;
        while (!seen && t < FLEN + 20) begin
            @(negedge clk);
            t++;
            if (tx_done_tick) seen = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        int gap;
        int dcnt;
        bit seen;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_done", {31'd0, tx_done_tick}, 32'd0);
        chk_en = 1'b1;
        reset  = 1'b0;

        // Idle with no request
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) bad++;
        end
        check("idle2000_bad", bad, 0);

        // 0xA5 with a spurious 0xFF request mid-frame
        literal_frame("a5", 8'hA5, A5_BITS, FRAME_LIT, 1'b1);

        // Back-to-back frames with tx_start held high
        @(negedge clk);
        din      = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        din = 8'hC3;
        wait_done(seen);
        check("b2b_done1", {31'd0, seen}, 32'd1);
        gap = 0;
        @(negedge clk);
        while (!tx_busy && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        check("b2b_gap", gap, 1);
        tx_start = 1'b0;
        wait_done(seen);
        check("b2b_done2", {31'd0, seen}, 32'd1);

        // Reset during data bit 4 of 0x81
        @(negedge clk);
        din      = 8'h81;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (879) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
        reset = 1'b0;
        dcnt  = 0;
        repeat (FLEN + 50) begin
            @(negedge clk);
            if (tx_done_tick) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        literal_frame("r81", 8'h81, R81_BITS, FRAME_LIT, 1'b0);

`ifdef UART_TX_PARITY_EN
        literal_frame("p07", 8'h07, P07_BITS, 1760, 1'b0);
`endif

        // Randomised frames with random gaps and ignored mid-frame requests
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            din      = 8'($urandom);
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            seen     = 1'b0;
            for (int t = 0; t < FLEN + 20 && !seen; t++) begin
                @(negedge clk);
                if (tx_done_tick) begin
                    seen     = 1'b1;
                    tx_start = 1'b0;
                end else if ($urandom_range(0, 199) == 0) begin
                    din      = 8'($urandom);
                    tx_start = 1'b1;
                end else begin
                    tx_start = 1'b0;
                end
            end
            tx_start = 1'b0;
            check("rand_done", {31'd0, seen}, 32'd1);
        end

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
